// File: rtl/posi_sched.sv
// CTU scheduler: sequences pre-transfer, intra engine and post-transfer per CTU,
// with a one-entry pending buffer for start requests arriving while busy.
`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 8
`endif

module posi_sched #(
  parameter logic MODE_PRE = 1'b0,
  parameter logic MODE_POS = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start_i,
  input  logic [`PIC_X_WIDTH-1:0] ctu_x_i,
  output logic                    done_o,
  output logic                    busy_o,
  output logic                    err_o,
  output logic                    trn_start_o,
  output logic                    trn_mode_o,
  output logic [`PIC_X_WIDTH-1:0] trn_ctu_x_o,
  input  logic                    trn_done_i,
  output logic                    eng_start_o,
  input  logic                    eng_done_i,
  output logic                    ori_sel_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, ENG = 2'd2, POS = 2'd3} state_t;

  state_t                    state_q, state_d;
  logic [`PIC_X_WIDTH-1:0]   x_q, x_d;
  logic                      pend_vld_q, pend_vld_d;
  logic [`PIC_X_WIDTH-1:0]   pend_x_q, pend_x_d;
  logic                      trn_start_q, trn_start_d;
  logic                      eng_start_q, eng_start_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      consume;
  logic                      store;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    pend_vld_d  = pend_vld_q;
    pend_x_d    = pend_x_q;
    trn_start_d = 1'b0;
    eng_start_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    consume     = (state_q == IDLE) && pend_vld_q;
    // A start arriving while a pending entry is being consumed refills the buffer.
    store       = start_i && ((state_q != IDLE) || consume);

    case (state_q)
      IDLE: begin
        if (pend_vld_q) begin
          state_d     = PRE;
          x_d         = pend_x_q;
          trn_start_d = 1'b1;
        end else if (start_i) begin
          state_d     = PRE;
          x_d         = ctu_x_i;
          trn_start_d = 1'b1;
        end
      end
      PRE: begin
        if (trn_done_i) begin
          state_d     = ENG;
          eng_start_d = 1'b1;
        end
      end
      ENG: begin
        if (eng_done_i) begin
          state_d     = POS;
          trn_start_d = 1'b1;
        end
      end
      POS: begin
        if (trn_done_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (consume) begin
      pend_vld_d = 1'b0;
    end
    if (store) begin
      if (pend_vld_q && !consume) begin
        err_d = 1'b1;
      end else begin
        pend_vld_d = 1'b1;
        pend_x_d   = ctu_x_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      x_q         <= '0;
      pend_vld_q  <= 1'b0;
      pend_x_q    <= '0;
      trn_start_q <= 1'b0;
      eng_start_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      pend_vld_q  <= pend_vld_d;
      pend_x_q    <= pend_x_d;
      trn_start_q <= trn_start_d;
      eng_start_q <= eng_start_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign ori_sel_o   = (state_q == ENG);
  assign trn_mode_o  = (state_q == POS) ? MODE_POS : MODE_PRE;
  assign trn_ctu_x_o = x_q;
  assign trn_start_o = trn_start_q;
  assign eng_start_o = eng_start_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_posi_sched.sv
// Directed bench for posi_sched: a transaction-level model (phase + request queue)
// is compared every cycle, plus literal checks at key points of each scenario.
`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 8
`endif

module tb_posi_sched;
  localparam int W = `PIC_X_WIDTH;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start_i = 1'b0;
  logic [W-1:0] ctu_x_i = '0;
  logic         trn_done_i = 1'b0;
  logic         eng_done_i = 1'b0;
  logic         done_o, busy_o, err_o, trn_start_o, trn_mode_o, eng_start_o, ori_sel_o;
  logic [W-1:0] trn_ctu_x_o;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  posi_sched dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .ctu_x_i(ctu_x_i),
    .done_o(done_o), .busy_o(busy_o), .err_o(err_o),
    .trn_start_o(trn_start_o), .trn_mode_o(trn_mode_o), .trn_ctu_x_o(trn_ctu_x_o),
    .trn_done_i(trn_done_i), .eng_start_o(eng_start_o), .eng_done_i(eng_done_i),
    .ori_sel_o(ori_sel_o)
  );

  always #5 clk = ~clk;

  // Model: phase 0=idle 1=pre 2=eng 3=pos; requests waiting are a queue capped at one.
  int           m_ph = 0;
  logic [W-1:0] m_x = '0;
  logic [W-1:0] m_pend[$];
  bit           m_done = 0, m_err = 0, m_ts = 0, m_es = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_ph = 0; m_x = '0; m_pend.delete();
      m_done = 0; m_err = 0; m_ts = 0; m_es = 0;
    end else begin
      m_done = 0; m_err = 0; m_ts = 0; m_es = 0;
      if (m_ph == 0) begin
        if (m_pend.size() > 0) begin
          m_x = m_pend.pop_front();
          m_ph = 1; m_ts = 1;
          if (start_i) m_pend.push_back(ctu_x_i);
        end else if (start_i) begin
          m_x = ctu_x_i;
          m_ph = 1; m_ts = 1;
        end
      end else begin
        if (start_i) begin
          if (m_pend.size() == 0) m_pend.push_back(ctu_x_i);
          else m_err = 1;
        end
        if (m_ph == 1 && trn_done_i) begin m_ph = 2; m_es = 1; end
        else if (m_ph == 2 && eng_done_i) begin m_ph = 3; m_ts = 1; end
        else if (m_ph == 3 && trn_done_i) begin m_ph = 0; m_done = 1; end
      end
    end
  end

  always @(negedge clk) begin
    logic [W+6:0] act, exp;
    act = {busy_o, done_o, err_o, trn_start_o, trn_mode_o, eng_start_o, ori_sel_o, trn_ctu_x_o};
    exp = {m_ph != 0, m_done, m_err, m_ts, m_ph == 3, m_es, m_ph == 2, m_x};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL cycle_cmp @%0t: got %h, required %h (busy,done,err,trn_start,mode,eng_start,ori_sel,x)",
               $time, act, exp);
    end
    if (done_o) done_cnt++;
    if (err_o) err_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    start_i = 0; trn_done_i = 0; eng_done_i = 0;
  endtask

  function automatic bit sig(input int s);
    case (s)
      0: return trn_start_o;
      1: return eng_start_o;
      default: return done_o;
    endcase
  endfunction

  task automatic wait_out(input int s, input string nm);
    int n = 0;
    while (!sig(s) && n < 200) begin step(); n++; end
    if (!sig(s)) begin
      tests++; fails++;
      $display("FAIL wait_%s: no pulse after %0d cycles, required a pulse", nm, n);
    end
  endtask

  // From a visible PRE trn_start pulse to the end of the sequence, zero-wait transfers.
  task automatic finish_seq();
    trn_done_i = 1; step();
    wait_out(1, "eng_start");
    eng_done_i = 1; step();
    wait_out(0, "pos_start");
    trn_done_i = 1; step();
    wait_out(2, "done");
    step();
  endtask

  task automatic run_seq(input logic [W-1:0] x, input int tw, input int ew);
    start_i = 1; ctu_x_i = x; step();
    wait_out(0, "pre_start");
    chk("pre_mode", trn_mode_o, 0);
    chk("pre_x", trn_ctu_x_o, x);
    repeat (tw) step();
    trn_done_i = 1; step();
    wait_out(1, "eng_start");
    chk("eng_ori_sel", ori_sel_o, 1);
    repeat (ew) step();
    eng_done_i = 1; step();
    wait_out(0, "pos_start");
    chk("pos_mode", trn_mode_o, 1);
    chk("pos_ori_sel", ori_sel_o, 0);
    chk("pos_x", trn_ctu_x_o, x);
    trn_done_i = 1; step();
    wait_out(2, "done");
    chk("done_idle", busy_o, 0);
    step();
  endtask

  initial begin
    rstn = 0;
    #1;
    chk("reset_outputs", {busy_o, done_o, err_o, trn_start_o, trn_mode_o, eng_start_o, ori_sel_o, trn_ctu_x_o}, 0);
    repeat (3) @(posedge clk);
    #2 rstn = 1;
    step();

    // Basic sequence with slow transfer and engine.
    run_seq(5, 19, 29);

    // Pending x=3 stored in PRE, x=4 dropped in ENG.
    start_i = 1; ctu_x_i = 1; step();
    wait_out(0, "s2_pre");
    step();
    start_i = 1; ctu_x_i = 3; step();
    trn_done_i = 1; step();
    wait_out(1, "s2_eng");
    start_i = 1; ctu_x_i = 4; step();
    chk("s2_err_pulse", err_o, 1);
    step();
    chk("s2_err_single", err_o, 0);
    eng_done_i = 1; step();
    wait_out(0, "s2_pos");
    trn_done_i = 1; step();
    wait_out(2, "s2_done");
    step();
    chk("s2_next_start", trn_start_o, 1);
    chk("s2_next_x", trn_ctu_x_o, 3);
    finish_seq();

    // Start coincident with final trn_done: one IDLE cycle then PRE with x=7.
    start_i = 1; ctu_x_i = 2; step();
    wait_out(0, "s3_pre");
    trn_done_i = 1; step();
    wait_out(1, "s3_eng");
    eng_done_i = 1; step();
    wait_out(0, "s3_pos");
    start_i = 1; ctu_x_i = 7; trn_done_i = 1; step();
    chk("s3_done", done_o, 1);
    chk("s3_idle_gap", busy_o, 0);
    step();
    chk("s3_pre_start", trn_start_o, 1);
    chk("s3_pre_x", trn_ctu_x_o, 7);
    chk("s3_pre_mode", trn_mode_o, 0);
    finish_seq();

    // Spurious done pulses are ignored.
    trn_done_i = 1; step();
    chk("s4_idle_trn_done", busy_o, 0);
    start_i = 1; ctu_x_i = 6; step();
    wait_out(0, "s4_pre");
    step();
    eng_done_i = 1; step();
    chk("s4_pre_eng_done", {ori_sel_o, eng_start_o, busy_o}, 3'b001);
    trn_done_i = 1; step();
    wait_out(1, "s4_eng");
    step();
    trn_done_i = 1; step();
    chk("s4_eng_trn_done", {ori_sel_o, trn_start_o, done_o}, 3'b100);
    eng_done_i = 1; step();
    wait_out(0, "s4_pos");
    trn_done_i = 1; step();
    wait_out(2, "s4_done");
    step();

    // Reset in ENG with a pending entry aborts everything.
    start_i = 1; ctu_x_i = 8; step();
    wait_out(0, "s5_pre");
    trn_done_i = 1; step();
    wait_out(1, "s5_eng");
    start_i = 1; ctu_x_i = 1; step();
    rstn = 0;
    #1;
    chk("s5_reset_outputs", {busy_o, done_o, err_o, trn_start_o, trn_mode_o, eng_start_o, ori_sel_o, trn_ctu_x_o}, 0);
    step(); step();
    rstn = 1;
    step(); step(); step();
    chk("s5_stays_idle", {busy_o, trn_start_o, done_o}, 0);
    run_seq(9, 3, 3);

    chk("total_done_pulses", done_cnt, 7);
    chk("total_err_pulses", err_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/posi_sched.md
POSI_SCHED -- requirements
Module: posi_sched

Interface
REQ-001 Parameter MODE_PRE, default 0, value driven on trn_mode_o for a pre-transfer.
REQ-002 Parameter MODE_POS, default 1, value driven on trn_mode_o for a post-transfer.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  one-cycle CTU start request.
REQ-006 ctu_x_i  input  `PIC_X_WIDTH  CTU x index; sampled with start_i.
REQ-007 done_o  output  1  one-cycle pulse when a CTU sequence completes.
REQ-008 busy_o  output  1  high whenever the state is not IDLE.
REQ-009 err_o  output  1  one-cycle pulse when a request overflows.
REQ-010 trn_start_o  output  1  one-cycle start pulse to the transfer unit.
REQ-011 trn_mode_o  output  1  transfer mode; MODE_PRE or MODE_POS.
REQ-012 trn_ctu_x_o  output  `PIC_X_WIDTH  CTU x of the active sequence.
REQ-013 trn_done_i  input  1  one-cycle done pulse from the transfer unit.
REQ-014 eng_start_o  output  1  one-cycle start pulse to the intra engine.
REQ-015 eng_done_i  input  1  one-cycle done pulse from the intra engine.
REQ-016 ori_sel_o  output  1  ori read-port owner; 0 = transfer unit, 1 = intra engine.

Function
REQ-017 The block SHALL implement states IDLE, PRE, ENG and POS, held in a 2-bit registered state.
REQ-018 IDLE->PRE SHALL occur when a request is available; the active CTU x SHALL be latched into trn_ctu_x_o.
- Pending request has priority over start_i.
REQ-019 On each entry to PRE, trn_start_o SHALL pulse for exactly 1 cycle with trn_mode_o=MODE_PRE, registered (the cycle after the transition decision).
REQ-020 PRE->ENG SHALL occur on trn_done_i; eng_start_o SHALL pulse 1 cycle later.
REQ-021 ENG->POS SHALL occur on eng_done_i; trn_start_o SHALL pulse 1 cycle later with trn_mode_o=MODE_POS.
REQ-022 POS->IDLE SHALL occur on trn_done_i, and done_o SHALL pulse in the following cycle.
REQ-023 If a pending request exists at POS->IDLE, the next PRE SHALL be entered in the cycle immediately after IDLE (one IDLE cycle minimum between sequences).
REQ-024 trn_mode_o SHALL hold MODE_POS during POS and MODE_PRE otherwise; trn_ctu_x_o SHALL be stable throughout a sequence.
REQ-025 ori_sel_o SHALL be 1 only in ENG, and 0 in IDLE, PRE and POS.
REQ-026 Done pulses that do not match the state SHALL be ignored; this covers trn_done_i in IDLE/ENG and eng_done_i outside ENG.
REQ-027 start_i while busy_o=1, or in the IDLE cycle in which a pending request is consumed, SHALL be stored in a one-entry pending buffer holding the valid flag and ctu_x.
REQ-028 start_i when the pending buffer is already valid SHALL be dropped, with err_o pulsing 1 cycle later; the existing pending entry SHALL be unchanged.
REQ-029 The pending buffer SHALL be cleared in the same cycle it is consumed; start_i in that cycle SHALL refill it.
REQ-030 start_i and trn_done_i together in POS SHALL complete the current CTU normally and store the new request as pending.
REQ-031 trn_done_i arriving in the same cycle as trn_start_o SHALL be treated as valid completion (zero-wait transfer).

Reset
REQ-032 On rstn low, the state SHALL be IDLE and the pending buffer empty.
REQ-033 On rstn low, all outputs SHALL be 0, including trn_ctu_x_o and trn_mode_o (=MODE_PRE).
REQ-034 Reset asserted mid-sequence SHALL abort with no done_o pulse; after release the block SHALL wait for a new start_i.

Verification
REQ-035 start_i with ctu_x_i=5, trn_done_i 20 cycles after trn_start_o, eng_done_i 30 cycles after eng_start_o -> expected response:
- trn_start_o pulse with mode 0, then eng_start_o, then trn_start_o pulse with mode 1, then done_o;
- trn_ctu_x_o=5 throughout; ori_sel_o=1 only between eng_start_o and eng_done_i.
REQ-036 start_i (x=3) in PRE, then start_i (x=4) in ENG -> expected response:
- x=3 pending, x=4 dropped, err_o single pulse;
- after done_o, second sequence runs with trn_ctu_x_o=3.
REQ-037 start_i (x=7) in the same cycle as trn_done_i in POS -> done_o for the current CTU, then one IDLE cycle, then PRE trn_start_o with trn_ctu_x_o=7.
REQ-038 Spurious trn_done_i in IDLE and in ENG, spurious eng_done_i in PRE -> no state change, no output pulses.
REQ-039 rstn deasserted-to-low during ENG with a pending entry -> all outputs 0, busy_o=0, no done_o; the next start_i (x=9) runs a full sequence with x=9.
